uart_rx_framer: RTL and testbench



---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_framer_if.sv | 32 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_framer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and small helpers for the UART receive framer.
// Latency: none (declarations only).
// Backpressure: not applicable. UART_RX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int SAMP_W        = 4;
    localparam int BITS_PER_CHAR = 10;
    localparam int IDLE_BITS_W   = 12;

    // Majority-vote sample positions inside a bit period; the decision is made at the last one.
    localparam logic [SAMP_W-1:0] VOTE_T0 = 4'd7;
    localparam logic [SAMP_W-1:0] VOTE_T1 = 4'd8;
    localparam logic [SAMP_W-1:0] VOTE_T2 = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        ST_BREAK  = 3'd4,
        ST_PARITY = 3'd5
`else
        ST_BREAK  = 3'd4
`endif
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Idle gap in bit times; a zero character count behaves as one character.
    function automatic logic [IDLE_BITS_W-1:0] idle_limit(input logic [7:0] idle_char);
        logic [IDLE_BITS_W-1:0] chars;
        chars = (idle_char == 8'd0) ? 12'd1 : {4'd0, idle_char};
        return chars * 12'(BITS_PER_CHAR);
    endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Receive-side byte/frame stream from the UART framer to the stream bridge, plus error reporting.
// Latency: none (wires only).
// Backpressure: none; all strobes are single-cycle and must be taken. UART_RX_PARITY_EN adds parity_err.
interface uart_rx_framer_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 rx_dvalid;
    logic [7:0]           rx_data;
    logic                 rx_start;
    logic                 rx_end;
    logic                 rx_state;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] frame_err_cnt;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output rx_dvalid, rx_data, rx_start, rx_end, rx_state, frame_err, frame_err_cnt
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        input rx_dvalid, rx_data, rx_start, rx_end, rx_state, frame_err, frame_err_cnt
`ifdef UART_RX_PARITY_EN
        , input parity_err
`endif
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every div+1 clocks, restartable to phase 0.
// Latency: first tick div+1 clocks after restart.
// Backpressure: none; free-running except while restart is held.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    // >= so a divisor lowered mid-count wraps at once instead of running to 0xFFFF.
    assign tick = !restart && (cnt >= div);

    // Divider counter; restart re-aligns the bit grid to a detected start edge.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt >= div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: syncs line, votes bits, checks stop (and parity with UART_RX_PARITY_EN), delimits frames by idle gap.
// Latency: 2 sync clocks + ~9.5 bit times (+1 bit with parity) + 1 clock from start edge to rx_dvalid.
// Backpressure: none; the serial line cannot stall, so every output strobe is a one-cycle pulse.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rxd,
    input  logic [15:0]         baud_div,
    input  logic [7:0]          idle_char,
`ifdef UART_RX_PARITY_EN
    input  logic                parity_odd,
`endif
    uart_rx_framer_if.master    rx_if
);

    localparam logic [SAMP_W-1:0] LAST_TICK = SAMP_W'(OVERSAMPLE - 1);

    uart_state_e state, state_nxt;

    logic                   rxd_s1, rxd_sync;
    logic [15:0]            div_q;
    logic                   tick;
    logic [SAMP_W-1:0]      samp_cnt;
    logic [2:0]             bit_cnt;
    logic                   v_a, v_b;
    logic                   vote;
    logic [7:0]             shreg;
    logic [SAMP_W-1:0]      brk_cnt;
    logic                   at_vote, at_bit_end;

    logic                   start_edge, shift_en, byte_good, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                   par_chk, par_fail, par_bad;
    logic                   par_err_q;
`endif

    logic                   dvalid_q, start_q, end_q, state_q, ferr_q;
    logic [7:0]             data_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic                   idle_run;
    logic [SAMP_W-1:0]      idle_sub;
    logic [IDLE_BITS_W-1:0] idle_bits;
    logic [IDLE_BITS_W-1:0] idle_lim_m1;
    logic                   frame_open;
    logic                   idle_restart;
    logic                   idle_expire;

    // Two-flop synchronizer; resets to the idle-high level so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1   <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_sync <= rxd_s1;
        end
    end

    // Divisor is captured only between characters so a change never distorts a byte in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (state == ST_IDLE) begin
            div_q <= baud_div;
        end
    end

    uart_baud_tick u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (start_edge),
        .div     (div_q),
        .tick    (tick)
    );

    assign vote       = maj3(v_a, v_b, rxd_sync);
    assign at_vote    = tick && (samp_cnt == VOTE_T2);
    assign at_bit_end = tick && (samp_cnt == LAST_TICK);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: start qualification, bit walk, stop check and break recovery.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rxd_sync) state_nxt = ST_START;
            end
            ST_START: begin
                if (at_vote && vote)  state_nxt = ST_IDLE;
                else if (at_bit_end)  state_nxt = ST_DATA;
            end
            ST_DATA: begin
`ifdef UART_RX_PARITY_EN
                if (at_bit_end && bit_cnt == 3'd7) state_nxt = ST_PARITY;
`else
                if (at_bit_end && bit_cnt == 3'd7) state_nxt = ST_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_bit_end) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (at_vote) state_nxt = vote ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (tick && rxd_sync && brk_cnt == LAST_TICK) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: single-cycle decision strobes consumed by the datapath and framer.
    always_comb begin
        start_edge = 1'b0;
        shift_en   = 1'b0;
        byte_good  = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk    = 1'b0;
        par_fail   = 1'b0;
`endif
        case (state)
            ST_IDLE:   start_edge = !rxd_sync;
            ST_DATA:   shift_en   = at_vote;
`ifdef UART_RX_PARITY_EN
            ST_PARITY: par_chk    = at_vote;
            ST_STOP: begin
                byte_good = at_vote && vote && !par_bad;
                par_fail  = at_vote && vote && par_bad;
                stop_bad  = at_vote && !vote;
            end
`else
            ST_STOP: begin
                byte_good = at_vote && vote;
                stop_bad  = at_vote && !vote;
            end
`endif
            default: ;
        endcase
    end

    // Bit-period sampling: tick position, vote samples, data shift, bit count, break-high run.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            v_a      <= 1'b1;
            v_b      <= 1'b1;
            shreg    <= '0;
            brk_cnt  <= '0;
        end else begin
            if (start_edge)  samp_cnt <= '0;
            else if (tick)   samp_cnt <= samp_cnt + 4'd1;

            if (tick && samp_cnt == VOTE_T0) v_a <= rxd_sync;
            if (tick && samp_cnt == VOTE_T1) v_b <= rxd_sync;

            if (start_edge)                            bit_cnt <= '0;
            else if (state == ST_DATA && at_bit_end)   bit_cnt <= bit_cnt + 3'd1;

            if (shift_en) shreg <= {vote, shreg[7:1]};

            if (state != ST_BREAK) brk_cnt <= '0;
            else if (tick)         brk_cnt <= rxd_sync ? brk_cnt + 4'd1 : '0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity compare against the received byte; parity_odd flips the expected bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad <= 1'b0;
        end else if (par_chk) begin
            par_bad <= (vote != (^shreg ^ parity_odd));
        end
    end
`endif

    // A frame counts as open from the rx_start cycle, one clock before rx_state rises.
    assign frame_open = state_q || start_q;
`ifdef UART_RX_PARITY_EN
    assign idle_restart = byte_good || ((stop_bad || par_fail) && frame_open);
`else
    assign idle_restart = byte_good || (stop_bad && frame_open);
`endif
    assign idle_lim_m1 = idle_limit(idle_char) - 12'd1;
    assign idle_expire = idle_run && frame_open && tick &&
                         (idle_sub == LAST_TICK) && (idle_bits >= idle_lim_m1);

    // Idle-gap timer in bit times; a start edge halts it, expiry is still reported on that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_run  <= 1'b0;
            idle_sub  <= '0;
            idle_bits <= '0;
        end else if (idle_restart) begin
            idle_run  <= 1'b1;
            idle_sub  <= '0;
            idle_bits <= '0;
        end else if (start_edge || idle_expire) begin
            idle_run  <= 1'b0;
            idle_sub  <= '0;
            idle_bits <= '0;
        end else if (idle_run && tick) begin
            idle_sub <= idle_sub + 4'd1;
            if (idle_sub == LAST_TICK) idle_bits <= idle_bits + 12'd1;
        end
    end

    // Registered output strobes, held byte, frame flag and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvalid_q  <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            state_q   <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            dvalid_q <= byte_good;
            start_q  <= byte_good && !frame_open;
            end_q    <= idle_expire;
            ferr_q   <= stop_bad;
            if (byte_good)                   data_q    <= shreg;
            if (stop_bad && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            if (start_q)    state_q <= 1'b1;
            else if (end_q) state_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error strobe, aligned with where rx_dvalid would have been.
    always_ff @(posedge clk) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= par_fail;
    end
    assign rx_if.parity_err = par_err_q;
`endif

    assign rx_if.rx_dvalid     = dvalid_q;
    assign rx_if.rx_data       = data_q;
    assign rx_if.rx_start      = start_q;
    assign rx_if.rx_end        = end_q;
    assign rx_if.rx_state      = state_q;
    assign rx_if.frame_err     = ferr_q;
    assign rx_if.frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: serial stimulus with a byte scoreboard and strobe counters.
// Latency: drives 16 clocks per bit (baud_div=0).
// Backpressure: none; the monitor samples every falling edge.
`timescale 1ns/1ps
module tb_uart_rx_framer;

    localparam int BIT_CLKS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rxd;
    logic [15:0] baud_div;
    logic [7:0]  idle_char;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd;
    logic        par_flip;
    int          n_perr;
`endif

    uart_rx_framer_if #(.ERR_CNT_W(16)) rx_if ();

    uart_rx_framer #(.OVERSAMPLE(16), .ERR_CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .baud_div  (baud_div),
        .idle_char (idle_char),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .rx_if     (rx_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_dv = 0, n_start = 0, n_end = 0, n_ferr = 0;
    int t_dv = 0, t_end = 0;
    int exp_err_cnt = 0;
    logic [7:0] sb_q [$];

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        int         gap_bits;
        logic       exp_good;
        logic       last;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: scoreboard pops on rx_dvalid, strobe counts and start/state relationships.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_dvalid) begin
                n_dv++;
                t_dv = cyc;
                if (sb_q.size() == 0) check("dvalid_with_empty_sb", sb_q.size(), 1);
                else                  check("rx_data", int'(rx_if.rx_data), int'(sb_q.pop_front()));
                if (rx_if.rx_start)   check("state_low_at_start", int'(rx_if.rx_state), 0);
            end
            if (rx_if.rx_start) begin
                n_start++;
                check("start_with_dvalid", int'(rx_if.rx_dvalid), 1);
            end
            if (rx_if.rx_end) begin
                n_end++;
                t_end = cyc;
            end
            if (rx_if.frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
            if (rx_if.parity_err) n_perr++;
`endif
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        wait_cycles(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ parity_odd ^ par_flip);
`endif
        send_bit(stop_b);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_end(input string name, input int base, input int bound);
        int i;
        i = 0;
        while (n_end == base && i < bound) begin
            wait_cycles(1);
            i++;
        end
        check(name, n_end - base, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dvalid"},   int'(rx_if.rx_dvalid), 0);
        check({tag, "_data"},     int'(rx_if.rx_data), 0);
        check({tag, "_start"},    int'(rx_if.rx_start), 0);
        check({tag, "_end"},      int'(rx_if.rx_end), 0);
        check({tag, "_state"},    int'(rx_if.rx_state), 0);
        check({tag, "_ferr"},     int'(rx_if.frame_err), 0);
        check({tag, "_ferr_cnt"}, int'(rx_if.frame_err_cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int dv0, st0, en0, fe0, exp_dv, exp_fe;

        vecs[0] = '{8'h01, 1'b1, 0, 1'b1, 1'b0};
        vecs[1] = '{8'h02, 1'b1, 0, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 0, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1, 1'b1, 1'b0};
        vecs[4] = '{8'h99, 1'b0, 2, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 0, 1'b1, 1'b1};

        rst       = 1'b1;
        uart_rxd  = 1'b1;
        baud_div  = 16'd0;
        idle_char = 8'd2;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        par_flip   = 1'b0;
        n_perr     = 0;
`endif
        wait_cycles(5);
        check_zero_outputs("reset");
        rst = 1'b0;
        wait_cycles(10);

        // Single byte: data, rx_start coincidence, open frame, idle-gap timing.
        st0 = n_start; en0 = n_end; dv0 = n_dv;
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_cycles(100);
        check("A_state_open", int'(rx_if.rx_state), 1);
        check("A_dvalid_cnt", n_dv - dv0, 1);
        check("A_start_cnt", n_start - st0, 1);
        wait_end("A_end_seen", en0, 1000);
        check_range("A_end_gap", t_end - t_dv, 320 - 16, 320 + 16);
        wait_cycles(2);
        check("A_state_closed", int'(rx_if.rx_state), 0);

        // Table-driven frames; each group ends with an idle-gap rx_end.
        dv0 = n_dv; st0 = n_start; en0 = n_end; fe0 = n_ferr; exp_dv = 0; exp_fe = 0;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].exp_good) begin
                sb_q.push_back(vecs[v].data);
                exp_dv++;
            end
            if (!vecs[v].stop_b) begin
                exp_fe++;
                exp_err_cnt++;
            end
            send_frame(vecs[v].data, vecs[v].stop_b);
            wait_cycles(vecs[v].gap_bits * BIT_CLKS);
            if (vecs[v].last) begin
                wait_end($sformatf("T%0d_end_seen", v), en0, 1000);
                check($sformatf("T%0d_dvalid_cnt", v), n_dv - dv0, exp_dv);
                check($sformatf("T%0d_start_cnt", v), n_start - st0, 1);
                check($sformatf("T%0d_ferr_cnt", v), n_ferr - fe0, exp_fe);
                check($sformatf("T%0d_sb_drained", v), sb_q.size(), 0);
                wait_cycles(5);
                dv0 = n_dv; st0 = n_start; en0 = n_end; fe0 = n_ferr; exp_dv = 0; exp_fe = 0;
            end
        end
        check("T_err_counter", int'(rx_if.frame_err_cnt), exp_err_cnt);

        // False start: 4-clock glitch produces nothing; the next byte still decodes.
        dv0 = n_dv; st0 = n_start; fe0 = n_ferr; en0 = n_end;
        uart_rxd = 1'b0;
        wait_cycles(4);
        uart_rxd = 1'b1;
        wait_cycles(100);
        check("C_no_dvalid", n_dv - dv0, 0);
        check("C_no_start", n_start - st0, 0);
        check("C_no_ferr", n_ferr - fe0, 0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_cycles(5);
        check("C_recover_dvalid", n_dv - dv0, 1);
        wait_end("C_end_seen", en0, 1000);

        // Framing error, long break, then a clean byte.
        dv0 = n_dv; st0 = n_start; fe0 = n_ferr; en0 = n_end;
        send_frame(8'h55, 1'b0);
        exp_err_cnt++;
        uart_rxd = 1'b0;
        wait_cycles(200);
        uart_rxd = 1'b1;
        wait_cycles(40);
        check("D_ferr_once", n_ferr - fe0, 1);
        check("D_ferr_counter", int'(rx_if.frame_err_cnt), exp_err_cnt);
        check("D_no_dvalid_55", n_dv - dv0, 0);
        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_cycles(5);
        check("D_dvalid_3c", n_dv - dv0, 1);
        check("D_start_3c", n_start - st0, 1);
        wait_end("D_end_seen", en0, 1000);

`ifdef UART_RX_PARITY_EN
        // Even parity: wrong parity bit suppresses the byte, correct one delivers it.
        dv0 = n_dv; en0 = n_end;
        begin
            int pe0;
            pe0 = n_perr;
            parity_odd = 1'b0;
            par_flip   = 1'b1;
            send_frame(8'h07, 1'b1);
            wait_cycles(10);
            check("P_parity_err", n_perr - pe0, 1);
            check("P_no_dvalid", n_dv - dv0, 0);
            par_flip = 1'b0;
            sb_q.push_back(8'h07);
            send_frame(8'h07, 1'b1);
            wait_cycles(5);
            check("P_dvalid", n_dv - dv0, 1);
            check("P_no_extra_perr", n_perr - pe0, 1);
            wait_end("P_end_seen", en0, 1000);
        end
`endif

        // Reset mid-byte with a frame open: outputs clear, no rx_end, fresh rx_start after.
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_cycles(20);
        check("E_frame_open", int'(rx_if.rx_state), 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst      = 1'b1;
        uart_rxd = 1'b1;
        wait_cycles(2);
        check_zero_outputs("E_reset");
        rst = 1'b0;
        en0 = n_end; st0 = n_start; dv0 = n_dv;
        wait_cycles(500);
        check("E_no_end", n_end - en0, 0);
        check("E_no_dvalid", n_dv - dv0, 0);
        sb_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        wait_cycles(5);
        check("E_dvalid_42", n_dv - dv0, 1);
        check("E_fresh_start", n_start - st0, 1);
        wait_end("E_end_seen", en0, 1000);

        check("final_sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
